// File: rtl/ssi_pkg.sv
// rtl/ssi_pkg.sv - shared constants, FSM state type and width helpers for the SSI poll scheduler
package ssi_pkg;

  localparam int SSI_MAX_W = 40;
  localparam int SSI_WW    = 6;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SCAN    = 3'd1,
    ST_START   = 3'd2,
    ST_WAIT    = 3'd3,
    ST_RECOVER = 3'd4
  } ssi_state_e;

  // A frame needs at least one bit and cannot exceed the reader's shift register
  function automatic logic width_legal(input logic [SSI_WW-1:0] w);
    return (w != '0) && (w <= SSI_WW'(SSI_MAX_W));
  endfunction

  // Keeps bits below the frame width; anything shifted in beyond the frame is junk
  function automatic logic [SSI_MAX_W-1:0] width_mask(input logic [SSI_WW-1:0] w);
    logic [SSI_MAX_W-1:0] m;
    for (int i = 0; i < SSI_MAX_W; i++) begin
      m[i] = (SSI_WW'(i) < w);
    end
    return m;
  endfunction

endpackage

// File: rtl/ssi_out_slot.sv
// rtl/ssi_out_slot.sv - single-entry valid/ready holding register for frame results
module ssi_out_slot #(
  parameter int CH_W = 2,
  parameter int DW   = 40
) (
  input  logic            enc_clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [CH_W-1:0] load_ch,
  input  logic [DW-1:0]   load_data,
  input  logic            ready,
  output logic            valid,
  output logic [CH_W-1:0] ch,
  output logic [DW-1:0]   data,
  output logic            full,
  output logic            accept
);

  assign accept = valid & ready;
  assign full   = valid;

  // Load wins over accept; the scheduler never loads while the slot is occupied
  always_ff @(posedge enc_clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      ch    <= '0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      ch    <= load_ch;
      data  <= load_data;
    end else if (accept) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ssi_poll_sched.sv
// rtl/ssi_poll_sched.sv - round-robin SSI encoder poll scheduler; frame timeout enabled by SSI_TIMEOUT_EN
module ssi_poll_sched
  import ssi_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int RECOVER_CYC = 42,
  parameter int TIMEOUT_CYC = 100
) (
  input  logic                    enc_clk,
  input  logic                    rst_n,
  input  logic [N_CH-1:0]         ch_en,
  input  logic [6*N_CH-1:0]       ch_width,
  input  logic [15:0]             poll_period,
  output logic                    rd_start,
  output logic [$clog2(N_CH)-1:0] rd_sel,
  output logic [5:0]              rd_width,
  input  logic                    rd_done,
  input  logic [SSI_MAX_W-1:0]    rd_pos,
  output logic                    pos_valid,
  input  logic                    pos_ready,
  output logic [$clog2(N_CH)-1:0] pos_ch,
  output logic [SSI_MAX_W-1:0]    pos_data,
  output logic [N_CH-1:0]         cfg_err,
  output logic [N_CH-1:0]         tmo_err
);

  localparam int CH_W    = $clog2(N_CH);
  localparam int CNT_MAX = (RECOVER_CYC > TIMEOUT_CYC) ? RECOVER_CYC : TIMEOUT_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

  ssi_state_e       state_q, state_d;
  logic [CH_W-1:0]  ptr_q;
  logic [15:0]      timer_q;
  logic [CNT_W-1:0] cnt_q;
  logic [N_CH-1:0]  cfg_err_q;

  logic             cur_en;
  logic [5:0]       cur_w;
  logic             round_due;
  logic             slot_full, slot_accept, slot_free;

  logic             ptr_clr, ptr_inc, timer_clr, cnt_clr, grab, fire, load;
  logic [N_CH-1:0]  cfg_set;
`ifdef SSI_TIMEOUT_EN
  logic             tmo_hit;
  logic [N_CH-1:0]  tmo_err_q;
`endif

  // Configuration of the channel under the round-robin pointer
  always_comb begin
    cur_en = 1'b0;
    cur_w  = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (ptr_q == CH_W'(i)) begin
        cur_en = ch_en[i];
        cur_w  = ch_width[6*i +: 6];
      end
    end
  end

  // The timer counts from the cycle the round started, so a round begins every poll_period cycles
  assign round_due = (poll_period == 16'd0) ||
                     (({1'b0, timer_q} + 17'd1) >= {1'b0, poll_period});

  assign slot_free = !slot_full || slot_accept;
  assign cfg_err   = cfg_err_q;

  // Next-state and per-cycle control strobes
  always_comb begin
    state_d   = state_q;
    ptr_clr   = 1'b0;
    ptr_inc   = 1'b0;
    timer_clr = 1'b0;
    cnt_clr   = 1'b0;
    grab      = 1'b0;
    fire      = 1'b0;
    load      = 1'b0;
    cfg_set   = '0;
`ifdef SSI_TIMEOUT_EN
    tmo_hit   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (round_due) begin
          state_d   = ST_SCAN;
          ptr_clr   = 1'b1;
          timer_clr = 1'b1;
        end
      end
      ST_SCAN: begin
        if (cur_en && width_legal(cur_w)) begin
          grab    = 1'b1;
          state_d = ST_START;
        end else begin
          if (cur_en) begin
            cfg_set = {{(N_CH-1){1'b0}}, 1'b1} << ptr_q;
          end
          if (ptr_q == LAST_CH) begin
            state_d = ST_IDLE;
          end else begin
            ptr_inc = 1'b1;
          end
        end
      end
      ST_START: begin
        if (slot_free) begin
          fire    = 1'b1;
          cnt_clr = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (rd_done) begin
          load    = 1'b1;
          cnt_clr = 1'b1;
          state_d = ST_RECOVER;
        end
`ifdef SSI_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          tmo_hit = 1'b1;
          cnt_clr = 1'b1;
          state_d = ST_RECOVER;
        end
`endif
      end
      ST_RECOVER: begin
        if (cnt_q == CNT_W'(RECOVER_CYC - 1)) begin
          if (ptr_q == LAST_CH) begin
            state_d = ST_IDLE;
          end else begin
            ptr_inc = 1'b1;
            state_d = ST_SCAN;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge enc_clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Pointer, timers, reader selection and sticky configuration errors
  always_ff @(posedge enc_clk) begin
    if (!rst_n) begin
      ptr_q     <= '0;
      timer_q   <= '0;
      cnt_q     <= '0;
      rd_start  <= 1'b0;
      rd_sel    <= '0;
      rd_width  <= '0;
      cfg_err_q <= '0;
    end else begin
      rd_start <= fire;
      if (ptr_clr) begin
        ptr_q <= '0;
      end else if (ptr_inc) begin
        ptr_q <= ptr_q + 1'b1;
      end
      if (timer_clr) begin
        timer_q <= '0;
      end else if (timer_q != '1) begin
        timer_q <= timer_q + 16'd1;
      end
      if (cnt_clr) begin
        cnt_q <= '0;
      end else if (cnt_q != '1) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (grab) begin
        rd_sel   <= ptr_q;
        rd_width <= cur_w;
      end
      cfg_err_q <= cfg_err_q | cfg_set;
    end
  end

`ifdef SSI_TIMEOUT_EN
  // A silent reader marks its channel; the result of that frame is simply never pushed
  always_ff @(posedge enc_clk) begin
    if (!rst_n) begin
      tmo_err_q <= '0;
    end else if (tmo_hit) begin
      tmo_err_q[rd_sel] <= 1'b1;
    end
  end
  assign tmo_err = tmo_err_q;
`else
  assign tmo_err = '0;
`endif

  ssi_out_slot #(
    .CH_W (CH_W),
    .DW   (SSI_MAX_W)
  ) u_slot (
    .enc_clk   (enc_clk),
    .rst_n     (rst_n),
    .load      (load),
    .load_ch   (rd_sel),
    .load_data (rd_pos & width_mask(rd_width)),
    .ready     (pos_ready),
    .valid     (pos_valid),
    .ch        (pos_ch),
    .data      (pos_data),
    .full      (slot_full),
    .accept    (slot_accept)
  );

endmodule

// File: tb/tb_ssi_poll_sched.sv
// tb/tb_ssi_poll_sched.sv - self-checking bench for ssi_poll_sched with a behavioural reader and stream model
`timescale 1ns/1ps
module tb_ssi_poll_sched;
  import ssi_pkg::*;

  localparam int N_CH        = 4;
  localparam int RECOVER_CYC = 42;
  localparam int TIMEOUT_CYC = 100;
  localparam int CW          = $clog2(N_CH);

  logic                enc_clk = 1'b0;
  logic                rst_n;
  logic [N_CH-1:0]     ch_en;
  logic [6*N_CH-1:0]   ch_width;
  logic [15:0]         poll_period;
  logic                rd_start;
  logic [CW-1:0]       rd_sel;
  logic [5:0]          rd_width;
  logic                rd_done;
  logic [39:0]         rd_pos;
  logic                pos_valid;
  logic                pos_ready;
  logic [CW-1:0]       pos_ch;
  logic [39:0]         pos_data;
  logic [N_CH-1:0]     cfg_err;
  logic [N_CH-1:0]     tmo_err;

  always #250 enc_clk = ~enc_clk;

  ssi_poll_sched #(.N_CH(N_CH), .RECOVER_CYC(RECOVER_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .enc_clk(enc_clk), .rst_n(rst_n), .ch_en(ch_en), .ch_width(ch_width),
    .poll_period(poll_period), .rd_start(rd_start), .rd_sel(rd_sel), .rd_width(rd_width),
    .rd_done(rd_done), .rd_pos(rd_pos), .pos_valid(pos_valid), .pos_ready(pos_ready),
    .pos_ch(pos_ch), .pos_data(pos_data), .cfg_err(cfg_err), .tmo_err(tmo_err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int cfg_en [N_CH];
  int cfg_w  [N_CH];

  int              lat_min = 0;
  int              lat_max = 0;
  logic [N_CH-1:0] silent  = '0;
  bit              use_fixed = 1'b0;
  logic [39:0]     fixed_pos = '0;
  bit              stray_req = 1'b0;
  int              start_cnt = 0;

  logic [39:0]     exp_data_q[$];
  logic [CW-1:0]   got_ch_q[$];
  logic [39:0]     got_data_q[$];

  always @(posedge enc_clk) cyc <= cyc + 1;

  function automatic logic [39:0] mask_of(input int w);
    logic [63:0] m;
    if (w >= 40) return 40'hFF_FFFF_FFFF;
    m = (64'd1 << w) - 64'd1;
    return m[39:0];
  endfunction

  function automatic bit legal(input int w);
    return (w >= 1) && (w <= 40);
  endfunction

  function automatic int next_ch(input int prev);
    for (int k = 1; k <= N_CH; k++) begin
      int c;
      c = (prev + k) % N_CH;
      if (cfg_en[c] != 0 && legal(cfg_w[c])) return c;
    end
    return -1;
  endfunction

  // Behavioural SSI reader: answers each rd_start after a random latency unless the channel is silent
  initial begin
    int lat;
    int ch;
    bit busy;
    logic [39:0] v;
    rd_done = 1'b0; rd_pos = '0; busy = 1'b0; lat = 0; ch = 0;
    forever begin
      @(negedge enc_clk);
      rd_done = 1'b0;
      if (stray_req) begin
        stray_req = 1'b0;
        rd_done = 1'b1;
        rd_pos = 40'({$urandom(), $urandom()});
      end
      if (!rst_n) begin
        busy = 1'b0;
      end else if (busy) begin
        if (lat == 0) begin
          busy = 1'b0;
          if (!silent[ch]) begin
            v = use_fixed ? fixed_pos : 40'({$urandom(), $urandom()});
            rd_pos = v;
            rd_done = 1'b1;
            exp_data_q.push_back(v & mask_of(cfg_w[ch]));
          end
        end else begin
          lat--;
        end
      end else if (rd_start) begin
        busy = 1'b1;
        ch = int'(rd_sel);
        lat = int'($urandom_range(lat_max, lat_min));
        start_cnt++;
      end
    end
  end

  initial begin
    #(64'd90000 * 64'd500);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic apply_cfg();
    for (int i = 0; i < N_CH; i++) begin
      ch_en[i] = cfg_en[i][0];
      ch_width[6*i +: 6] = cfg_w[i][5:0];
    end
  endtask

  task automatic do_reset();
    apply_cfg();
    @(negedge enc_clk);
    rst_n = 1'b0;
    pos_ready = 1'b0;
    repeat (3) @(negedge enc_clk);
    exp_data_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic drain(input int n, input int max_cyc, input int ready_pct, output int got);
    got_ch_q.delete();
    got_data_q.delete();
    got = 0;
    for (int c = 0; c < max_cyc && got < n; c++) begin
      @(negedge enc_clk);
      pos_ready = ($urandom_range(99, 0) < ready_pct);
      if (pos_valid && pos_ready) begin
        got_ch_q.push_back(pos_ch);
        got_data_q.push_back(pos_data);
        got++;
      end
    end
    @(posedge enc_clk);
    #1 pos_ready = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < N_CH; i++) begin cfg_en[i] = 0; cfg_w[i] = 25; end
    apply_cfg();
    poll_period = 16'd0; pos_ready = 1'b0; rst_n = 1'b0;
    repeat (3) @(negedge enc_clk);
    n_checks++; if (rd_start !== 1'b0) begin n_fail++; $display("FAIL reset_rd_start: got %0b expected 0", rd_start); end
    n_checks++; if (pos_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pos_valid: got %0b expected 0", pos_valid); end
    n_checks++; if (pos_data !== 40'd0 || pos_ch !== '0) begin n_fail++; $display("FAIL reset_pos: got ch %0d data %0h expected 0/0", pos_ch, pos_data); end
    n_checks++; if (rd_sel !== '0 || rd_width !== 6'd0) begin n_fail++; $display("FAIL reset_rd_sel: got %0d/%0d expected 0/0", rd_sel, rd_width); end
    n_checks++; if (cfg_err !== '0 || tmo_err !== '0) begin n_fail++; $display("FAIL reset_err: got %b/%b expected 0/0", cfg_err, tmo_err); end
    n_checks++; if (dut.state_q !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", dut.state_q, ST_IDLE); end
  endtask

  task automatic test_round_robin();
    int got;
    for (int i = 0; i < N_CH; i++) begin cfg_en[i] = (i % 2 == 0); cfg_w[i] = 25; end
    poll_period = 16'd0; use_fixed = 1'b1; fixed_pos = 40'h1ABCDEF; lat_min = 0; lat_max = 5; silent = '0;
    do_reset();
    drain(6, 2000, 100, got);
    n_checks++; if (got != 6) begin n_fail++; $display("FAIL rr_count: got %0d expected 6", got); end
    for (int k = 0; k < got; k++) begin
      n_checks++; if (got_ch_q[k] !== CW'((k % 2) * 2)) begin n_fail++; $display("FAIL rr_ch[%0d]: got %0d expected %0d", k, got_ch_q[k], (k % 2) * 2); end
      n_checks++; if (got_data_q[k] !== 40'h1ABCDEF) begin n_fail++; $display("FAIL rr_data[%0d]: got %0h expected 1abcdef", k, got_data_q[k]); end
    end
  endtask

  task automatic test_mask();
    int got;
    int widths [2];
    logic [39:0] expv [2];
    widths[0] = 13; expv[0] = 40'h1FFF;
    widths[1] = 40; expv[1] = 40'hFF_FFFF_FFFF;
    for (int t = 0; t < 2; t++) begin
      for (int i = 0; i < N_CH; i++) begin cfg_en[i] = (i == 0); cfg_w[i] = widths[t]; end
      poll_period = 16'd0; use_fixed = 1'b1; fixed_pos = 40'hFF_FFFF_FFFF; lat_min = 0; lat_max = 3;
      do_reset();
      drain(2, 1000, 100, got);
      n_checks++; if (got != 2) begin n_fail++; $display("FAIL mask_count w%0d: got %0d expected 2", widths[t], got); end
      for (int k = 0; k < got; k++) begin
        n_checks++; if (got_data_q[k] !== expv[t]) begin n_fail++; $display("FAIL mask_data w%0d: got %0h expected %0h", widths[t], got_data_q[k], expv[t]); end
      end
    end
  endtask

  task automatic test_backpressure();
    int got, s0, bad_valid, bad_data, waited;
    logic [CW-1:0] held_ch;
    logic [39:0]   held_data, exp_first;
    for (int i = 0; i < N_CH; i++) begin cfg_en[i] = (i % 2 == 0); cfg_w[i] = 25; end
    poll_period = 16'd0; use_fixed = 1'b0; lat_min = 0; lat_max = 4;
    do_reset();
    waited = 0;
    while (!pos_valid && waited < 500) begin @(negedge enc_clk); waited++; end
    n_checks++; if (!pos_valid) begin n_fail++; $display("FAIL bp_first_valid: got 0 expected 1 within 500 cycles"); end
    held_ch = pos_ch; held_data = pos_data; s0 = start_cnt; bad_valid = 0; bad_data = 0;
    exp_first = (exp_data_q.size() > 0) ? exp_data_q[0] : 40'hX;
    n_checks++; if (held_ch !== '0 || held_data !== exp_first) begin n_fail++; $display("FAIL bp_first_item: got ch %0d data %0h expected 0/%0h", held_ch, held_data, exp_first); end
    repeat (500) begin
      @(negedge enc_clk);
      if (!pos_valid) bad_valid++;
      if (pos_ch !== held_ch || pos_data !== held_data) bad_data++;
    end
    n_checks++; if (bad_valid != 0) begin n_fail++; $display("FAIL bp_valid_held: got %0d drops expected 0", bad_valid); end
    n_checks++; if (bad_data != 0) begin n_fail++; $display("FAIL bp_data_stable: got %0d changes expected 0", bad_data); end
    n_checks++; if (start_cnt != s0) begin n_fail++; $display("FAIL bp_no_start: got %0d starts expected 0", start_cnt - s0); end
    drain(3, 1000, 100, got);
    n_checks++; if (got != 3) begin n_fail++; $display("FAIL bp_drain_count: got %0d expected 3", got); end
    for (int k = 0; k < got; k++) begin
      logic [39:0] e;
      e = (exp_data_q.size() > 0) ? exp_data_q.pop_front() : 40'hX;
      n_checks++; if (got_ch_q[k] !== CW'((k % 2) * 2)) begin n_fail++; $display("FAIL bp_ch[%0d]: got %0d expected %0d", k, got_ch_q[k], (k % 2) * 2); end
      n_checks++; if (got_data_q[k] !== e) begin n_fail++; $display("FAIL bp_data[%0d]: got %0h expected %0h", k, got_data_q[k], e); end
    end
  endtask

  task automatic test_cfg_err();
    int s0, seen_valid, bad_state;
    for (int i = 0; i < N_CH; i++) begin cfg_en[i] = (i == 1); cfg_w[i] = (i == 1) ? 0 : 25; end
    poll_period = 16'd0; lat_min = 0; lat_max = 2;
    do_reset();
    s0 = start_cnt; seen_valid = 0; bad_state = 0;
    pos_ready = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge enc_clk);
      if (c == 100) stray_req = 1'b1;
      if (pos_valid) seen_valid++;
      if (dut.state_q !== ST_IDLE && dut.state_q !== ST_SCAN) bad_state++;
    end
    pos_ready = 1'b0;
    n_checks++; if (cfg_err !== 4'b0010) begin n_fail++; $display("FAIL cfg_err_flag: got %b expected 0010", cfg_err); end
    n_checks++; if (start_cnt != s0) begin n_fail++; $display("FAIL cfg_no_start: got %0d starts expected 0", start_cnt - s0); end
    n_checks++; if (seen_valid != 0) begin n_fail++; $display("FAIL cfg_stray_done: got %0d valid cycles expected 0", seen_valid); end
    n_checks++; if (bad_state != 0) begin n_fail++; $display("FAIL cfg_idle_scan: got %0d other-state cycles expected 0", bad_state); end
  endtask

  task automatic test_period();
    int t [3];
    int n;
    for (int i = 0; i < N_CH; i++) begin cfg_en[i] = (i == 0); cfg_w[i] = 16; end
    poll_period = 16'd200; use_fixed = 1'b0; lat_min = 3; lat_max = 3;
    do_reset();
    pos_ready = 1'b1; n = 0;
    for (int c = 0; c < 1000 && n < 3; c++) begin
      @(negedge enc_clk);
      if (rd_start) begin t[n] = cyc; n++; end
    end
    pos_ready = 1'b0;
    n_checks++; if (n != 3) begin n_fail++; $display("FAIL period_starts: got %0d expected 3", n); end
    if (n == 3) begin
      n_checks++; if (t[1] - t[0] != 200 || t[2] - t[1] != 200) begin n_fail++; $display("FAIL period_interval: got %0d/%0d expected 200/200", t[1] - t[0], t[2] - t[1]); end
    end
  endtask

  task automatic test_reset_mid_frame();
    int waited, s0;
    for (int i = 0; i < N_CH; i++) begin cfg_en[i] = (i % 2 == 0); cfg_w[i] = 25; end
    poll_period = 16'd0; use_fixed = 1'b0; lat_min = 0; lat_max = 2; silent = '1;
    do_reset();
    pos_ready = 1'b1; waited = 0;
    while (!rd_start && waited < 300) begin @(negedge enc_clk); waited++; end
    n_checks++; if (!rd_start) begin n_fail++; $display("FAIL rst_mid_start: got 0 expected a rd_start within 300 cycles"); end
    repeat (5) @(negedge enc_clk);
`ifndef SSI_TIMEOUT_EN
    s0 = start_cnt;
    repeat (150) @(negedge enc_clk);
    n_checks++; if (tmo_err !== '0) begin n_fail++; $display("FAIL tmo_tied: got %b expected 0000", tmo_err); end
    n_checks++; if (start_cnt != s0 || dut.state_q !== ST_WAIT) begin n_fail++; $display("FAIL wait_forever: got %0d starts state %0d expected 0/%0d", start_cnt - s0, dut.state_q, ST_WAIT); end
`endif
    rst_n = 1'b0;
    @(negedge enc_clk);
    n_checks++; if (dut.state_q !== ST_IDLE || pos_valid !== 1'b0 || rd_start !== 1'b0) begin n_fail++; $display("FAIL rst_mid_state: got state %0d valid %0b start %0b expected %0d/0/0", dut.state_q, pos_valid, rd_start, ST_IDLE); end
    silent = '0;
    exp_data_q.delete();
    rst_n = 1'b1;
    waited = 0;
    @(negedge enc_clk);
    while (!rd_start && waited < 300) begin @(negedge enc_clk); waited++; end
    n_checks++; if (!rd_start || rd_sel !== '0) begin n_fail++; $display("FAIL rst_mid_restart: got start %0b sel %0d expected 1/0", rd_start, rd_sel); end
    pos_ready = 1'b0;
  endtask

`ifdef SSI_TIMEOUT_EN
  task automatic test_timeout();
    int t3, tt, tn, sel_n, pushes3;
    for (int i = 0; i < N_CH; i++) begin cfg_en[i] = (i == 0 || i == 3); cfg_w[i] = 20; end
    poll_period = 16'd0; use_fixed = 1'b0; lat_min = 0; lat_max = 2; silent = 4'b1000;
    do_reset();
    pos_ready = 1'b1; t3 = -1; tt = -1; tn = -1; sel_n = -1; pushes3 = 0;
    for (int c = 0; c < 1000 && tn < 0; c++) begin
      @(negedge enc_clk);
      if (pos_valid && pos_ch == 2'd3) pushes3++;
      if (rd_start && rd_sel == 2'd3 && t3 < 0) t3 = cyc;
      if (tmo_err[3] && tt < 0) tt = cyc;
      else if (rd_start && tt >= 0) begin tn = cyc; sel_n = int'(rd_sel); end
    end
    pos_ready = 1'b0;
    n_checks++; if (tt - t3 != TIMEOUT_CYC || t3 < 0) begin n_fail++; $display("FAIL tmo_delay: got %0d expected %0d", tt - t3, TIMEOUT_CYC); end
    n_checks++; if (tmo_err !== 4'b1000) begin n_fail++; $display("FAIL tmo_flag: got %b expected 1000", tmo_err); end
    n_checks++; if (pushes3 != 0) begin n_fail++; $display("FAIL tmo_no_push: got %0d expected 0", pushes3); end
    n_checks++; if (sel_n != 0 || tn - tt < RECOVER_CYC) begin n_fail++; $display("FAIL tmo_next: got sel %0d gap %0d expected 0 and >= %0d", sel_n, tn - tt, RECOVER_CYC); end
    silent = '0;
  endtask
`endif

  task automatic test_random();
    int got, nleg, prev, e, s0;
    logic [N_CH-1:0] exp_cfg;
    for (int it = 0; it < 5; it++) begin
      nleg = 0; exp_cfg = '0;
      for (int i = 0; i < N_CH; i++) begin
        cfg_en[i] = int'($urandom_range(1, 0));
        if ($urandom_range(9, 0) < 7) cfg_w[i] = int'($urandom_range(40, 1));
        else cfg_w[i] = ($urandom_range(1, 0) == 0) ? 0 : int'($urandom_range(63, 41));
        if (cfg_en[i] != 0 && legal(cfg_w[i])) nleg++;
        if (cfg_en[i] != 0 && !legal(cfg_w[i])) exp_cfg[i] = 1'b1;
      end
      poll_period = 16'($urandom_range(120, 0)); use_fixed = 1'b0; lat_min = 0; lat_max = 6; silent = '0;
      do_reset();
      if (nleg == 0) begin
        s0 = start_cnt;
        repeat (300) @(negedge enc_clk);
        n_checks++; if (start_cnt != s0 || pos_valid !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_idle: got %0d starts valid %0b expected 0/0", it, start_cnt - s0, pos_valid); end
      end else begin
        drain(6, 3000, 60, got);
        n_checks++; if (got != 6) begin n_fail++; $display("FAIL rnd%0d_count: got %0d expected 6", it, got); end
        prev = N_CH - 1;
        for (int k = 0; k < got; k++) begin
          logic [39:0] ed;
          e = next_ch(prev); prev = e;
          ed = (exp_data_q.size() > 0) ? exp_data_q.pop_front() : 40'hX;
          n_checks++; if (int'(got_ch_q[k]) != e) begin n_fail++; $display("FAIL rnd%0d_ch[%0d]: got %0d expected %0d", it, k, got_ch_q[k], e); end
          n_checks++; if (got_data_q[k] !== ed) begin n_fail++; $display("FAIL rnd%0d_data[%0d]: got %0h expected %0h", it, k, got_data_q[k], ed); end
        end
      end
      n_checks++; if (cfg_err !== exp_cfg) begin n_fail++; $display("FAIL rnd%0d_cfg_err: got %b expected %b", it, cfg_err, exp_cfg); end
    end
  endtask

  initial begin
    rst_n = 1'b0; pos_ready = 1'b0; ch_en = '0; ch_width = '0; poll_period = '0;
    test_reset();
    test_round_robin();
    test_mask();
    test_backpressure();
    test_cfg_err();
    test_period();
    test_reset_mid_frame();
`ifdef SSI_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
